// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================
// fir_pkg : shared widths, FSM encoding and index helper for fir_seq
// Rev 1.0
// ============================================================
package fir_pkg;

    localparam int DW        = 8;
    localparam int CW        = 8;
    localparam int AW        = 20;
    localparam int NTAPS     = 11;
    localparam int NPAIRS    = 6;
    localparam int OUT_SHIFT = 7;
    localparam int OW        = 16;
    localparam int IDXW      = 4;
    localparam int PW        = DW + 1 + CW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Inputs never exceed 2*NTAPS-1, so a single conditional subtract wraps them.
    function automatic logic [IDXW-1:0] idx_wrap(input logic [IDXW:0] v);
        logic [IDXW:0] w_adj;
        w_adj = v - (IDXW+1)'(NTAPS);
        return (v >= (IDXW+1)'(NTAPS)) ? w_adj[IDXW-1:0] : v[IDXW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_seq_if.sv
`default_nettype none
// ============================================================
// fir_seq_if : sample, result, coefficient and control signals of fir_seq
// Rev 1.0
// ============================================================
interface fir_seq_if;
    import fir_pkg::*;

    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [OW-1:0]        out_data;
    logic                 out_ready;
    logic                 cfg_we;
    logic [2:0]           cfg_addr;
    logic signed [CW-1:0] cfg_data;
    logic                 cfg_err;
    logic                 flush;
    logic                 busy;

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, flush,
        output in_ready, out_valid, out_data, cfg_err, busy
    );

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, flush,
        input  in_ready, out_valid, out_data, cfg_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/fir_hist_buf.sv
`default_nettype none
// ============================================================
// fir_hist_buf : 11-entry circular sample history with two read ports
// Rev 1.0
// ============================================================
module fir_hist_buf
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic signed [DW-1:0] wdata,
    input  logic                 flush,
    input  logic [IDXW-1:0]      raddr_a,
    input  logic [IDXW-1:0]      raddr_b,
    output logic signed [DW-1:0] rdata_a,
    output logic signed [DW-1:0] rdata_b,
    output logic [IDXW-1:0]      wptr
);

    logic signed [DW-1:0] r_mem [NTAPS];
    logic [IDXW-1:0]      r_wptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[r_wptr] <= wdata;
            r_wptr        <= idx_wrap({1'b0, r_wptr} + 5'd1);
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];
    assign wptr    = r_wptr;

endmodule
`default_nettype wire

// File: rtl/fir_seq.sv
`default_nettype none
// ============================================================
// fir_seq : time-shared symmetric 11-tap FIR (one pre-adder, one MAC)
// Rev 1.0
// ============================================================
module fir_seq
    import fir_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fir_seq_if.slave bus
);

    localparam logic [2:0]      C_K_LAST   = 3'(NPAIRS - 1);
    localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(NTAPS - 1);
    localparam logic [IDXW:0]   C_NTAPS    = (IDXW+1)'(NTAPS);

    state_t               r_state, w_next;
    logic [2:0]           r_k;
    logic signed [AW-1:0] r_acc;
    logic signed [CW-1:0] r_coef [NPAIRS];
    logic [OW-1:0]        r_out_data;
    logic                 r_cfg_err;

    logic                 w_idle, w_accept, w_flush, w_in_ready, w_out_valid, w_busy;
    logic [IDXW-1:0]      w_wptr, w_newest, w_raddr_a, w_raddr_b;
    logic signed [DW-1:0] w_xa, w_xb;
    logic signed [DW:0]   w_pair, w_pre;
    logic signed [CW-1:0] w_coef;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Flush outranks a sample, so in_ready drops while flush is requested.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_in_ready = !bus.flush;
                if (bus.in_valid && !bus.flush) w_next = S_MAC;
            end
            S_MAC: begin
                if (r_k == C_K_LAST) w_next = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_flush  = bus.flush && w_idle;

    fir_hist_buf u_hist (
        .clk     (clk),
        .rst     (rst),
        .we      (w_accept),
        .wdata   (bus.in_data),
        .flush   (w_flush),
        .raddr_a (w_raddr_a),
        .raddr_b (w_raddr_b),
        .rdata_a (w_xa),
        .rdata_b (w_xb),
        .wptr    (w_wptr)
    );

    // Port A walks back from the newest sample, port B forward from the oldest.
    assign w_newest  = (w_wptr == '0) ? C_IDX_LAST : w_wptr - 1'b1;
    assign w_raddr_a = idx_wrap({1'b0, w_newest} + C_NTAPS - {2'b00, r_k});
    assign w_raddr_b = idx_wrap({1'b0, w_wptr} + {2'b00, r_k});

    assign w_pair = (r_k == C_K_LAST) ? '0 : {w_xb[DW-1], w_xb};
    assign w_pre  = {w_xa[DW-1], w_xa} + w_pair;
    assign w_coef = r_coef[r_k];
    assign w_prod = PW'(w_pre) * PW'(w_coef);
    assign w_sum  = r_acc + AW'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_cfg_err  <= 1'b0;
            for (int i = 0; i < NPAIRS; i++) r_coef[i] <= '0;
        end else begin
            r_cfg_err <= bus.cfg_we && !w_idle;
            if (bus.cfg_we && w_idle && (bus.cfg_addr <= C_K_LAST))
                r_coef[bus.cfg_addr] <= bus.cfg_data;
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_sum;
                if (r_k == C_K_LAST) begin
                    r_k        <= '0;
                    r_out_data <= {{(OW-(AW-OUT_SHIFT)){w_sum[AW-1]}}, w_sum[AW-1:OUT_SHIFT]};
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fir_seq.sv
`default_nettype none
// ============================================================
// tb_fir_seq : directed self-checking bench for fir_seq
// Rev 1.0
// ============================================================
module tb_fir_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    fir_seq_if bus ();

    fir_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic signed [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg_all(input logic signed [7:0] c0, c1, c2, c3, c4, c5);
        cfg_write(3'd0, c0);
        cfg_write(3'd1, c1);
        cfg_write(3'd2, c2);
        cfg_write(3'd3, c3);
        cfg_write(3'd4, c4);
        cfg_write(3'd5, c5);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    // Sends one sample from IDLE with out_ready high; returns result and latency.
    task automatic run_sample(input logic signed [7:0] d, output logic [15:0] res, output int lat);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = bus.out_data;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", bus.out_data); else n_pass++;
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", bus.cfg_err); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_impulse();
        logic [15:0] exp_out [11] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd32,
                                      16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        logic [15:0] res;
        int lat;
        cfg_all(8'sd2, 8'sd4, 8'sd6, 8'sd8, 8'sd10, 8'sd64);
        do_flush();
        for (int i = 0; i < 11; i++) begin
            run_sample((i == 0) ? 8'sd64 : 8'sd0, res, lat);
            if (i == 0) begin
                n_total++; if (lat !== 7) $display("FAIL impulse_latency: got %0d want 7", lat); else n_pass++;
            end
            n_total++; if (res !== exp_out[i]) $display("FAIL impulse[%0d]: got %0d want %0d", i, $signed(res), exp_out[i]); else n_pass++;
        end
    endtask

    task automatic test_dc_max();
        logic [15:0] res;
        int lat;
        cfg_all(8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127);
        do_flush();
        for (int i = 0; i < 11; i++) begin
            run_sample(8'sd127, res, lat);
            if (i == 0) begin
                n_total++; if (res !== 16'd126) $display("FAIL dc_first: got %0d want 126", $signed(res)); else n_pass++;
            end
        end
        n_total++; if (res !== 16'h056A) $display("FAIL dc_max: got %h want 056a", res); else n_pass++;
    endtask

    task automatic test_floor();
        logic [15:0] res;
        int lat;
        cfg_all(8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1);
        do_flush();
        run_sample(-8'sd1, res, lat);
        n_total++; if (res !== 16'h0000) $display("FAIL floor_first: got %h want 0000", res); else n_pass++;
        for (int i = 0; i < 5; i++) run_sample(8'sd0, res, lat);
        n_total++; if (res !== 16'hFFFF) $display("FAIL floor_sixth: got %h want ffff", res); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int lat;
        cfg_all(8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
        do_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'sd100;
        tick();
        bus.in_data = 8'sd20;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_total++; if (lat !== 7) $display("FAIL bp_latency: got %0d want 7", lat); else n_pass++;
        held = bus.out_data;
        n_total++; if (held !== 16'd50) $display("FAIL bp_data: got %0d want 50", $signed(held)); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1 %h 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, held);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        n_total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_after_hs: got busy=%b ready=%b want 0 1", bus.busy, bus.in_ready); else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL bp_accept: got busy=%b want 1", bus.busy); else n_pass++;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_total++; if (bus.out_data !== 16'd10 || bus.out_valid !== 1'b1)
            $display("FAIL bp_second: got %0d valid=%b want 10", $signed(bus.out_data), bus.out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_cfg_busy();
        logic [15:0] res;
        int lat;
        do_flush();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd40;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'sd127;
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL cfgbusy_pre: got %b want 0", bus.cfg_err); else n_pass++;
        tick();
        bus.cfg_we = 1'b0;
        n_total++; if (bus.cfg_err !== 1'b1) $display("FAIL cfgbusy_pulse: got %b want 1", bus.cfg_err); else n_pass++;
        tick();
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL cfgbusy_end: got %b want 0", bus.cfg_err); else n_pass++;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_total++; if (bus.out_data !== 16'd20 || bus.out_valid !== 1'b1)
            $display("FAIL cfgbusy_result: got %0d valid=%b want 20", $signed(bus.out_data), bus.out_valid); else n_pass++;
        tick();
        do_flush();
        run_sample(8'sd40, res, lat);
        n_total++; if (res !== 16'd20) $display("FAIL cfgbusy_coef_kept: got %0d want 20", $signed(res)); else n_pass++;
    endtask

    task automatic test_cfg_same_cycle();
        logic [15:0] res;
        int lat;
        do_flush();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'sd127;
        run_sample(8'sd40, res, lat);
        bus.cfg_we = 1'b0;
        n_total++; if (res !== 16'd39) $display("FAIL cfg_same_cycle: got %0d want 39", $signed(res)); else n_pass++;
        cfg_write(3'd6, 8'sd5);
        n_total++; if (bus.cfg_err !== 1'b0) $display("FAIL cfg_addr6_err: got %b want 0", bus.cfg_err); else n_pass++;
    endtask

    task automatic test_flush_priority();
        logic [15:0] res;
        int lat;
        cfg_all(8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd50;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL flush_not_accepted: got busy=%b want 0", bus.busy); else n_pass++;
        run_sample(8'sd0, res, lat);
        n_total++; if (res !== 16'd0) $display("FAIL flush_cleared: got %0d want 0", $signed(res)); else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [15:0] res;
        int lat;
        bit  seen;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd100;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL rst_mid_state: got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid); else n_pass++;
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rst_mid_no_out: got out_valid seen=%b want 0", seen); else n_pass++;
        run_sample(8'sd100, res, lat);
        n_total++; if (res !== 16'd0 || lat !== 7)
            $display("FAIL rst_mid_coef_zero: got %0d lat=%0d want 0 lat=7", $signed(res), lat); else n_pass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.flush     = 1'b0;
        test_reset();
        test_impulse();
        test_dc_max();
        test_floor();
        test_backpressure();
        test_cfg_busy();
        test_cfg_same_cycle();
        test_flush_priority();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fir_seq.md
FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 Parameters: DW=8 (sample width), CW=8 (signed coefficient width, Q1.7), AW=20 (accumulator width), NTAPS=11 (odd, symmetric), NPAIRS=6 (coefficients c0..c5).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1 / in_data  in  DW / in_ready  out  1: signed sample input with valid/ready handshake.
REQ-005 out_valid  out  1 / out_data  out  16 / out_ready  in  1: signed filtered output with valid/ready handshake.
REQ-006 cfg_we  in  1 / cfg_addr  in  3 / cfg_data  in  CW: coefficient write port.
REQ-007 cfg_err  out  1: one-cycle pulse when a coefficient write is rejected.
REQ-008 flush  in  1: clears the sample history when idle.
REQ-009 busy  out  1: high in any state other than IDLE.

Function
REQ-010 The block is a time-shared symmetric FIR sequencer: one pre-adder, one multiplier and one accumulator, sequenced by FSM states IDLE, MAC, OUT.
REQ-011 IDLE: in_ready=1; on in_valid&in_ready the sample is written at the write pointer, the pointer advances modulo NTAPS, acc clears, and the FSM goes to MAC with k=0.
REQ-012 MAC: 6 cycles, k=0..5; k<5: acc += (x[n-k]+x[n-10+k])*c[k], with the pre-add sign-extended to DW+1 bits; k=5: acc += x[n-5]*c5 (no pair).
REQ-013 Product width is DW+1+CW=17 bits signed, sign-extended into the AW-bit acc; no saturation is needed (|acc| < 2^19 is guaranteed).
REQ-014 After k=5 the FSM enters OUT; out_data = sign-extension of acc[19:7] (arithmetic shift right by 7, floor) to 16 bits.
REQ-015 Latency: sample accepted at cycle 0 -> out_valid=1 at cycle 7; minimum sample period 8 cycles.
REQ-016 OUT: out_valid and out_data are held stable until out_ready=1; the FSM returns to IDLE on the cycle after the handshake; in_ready=0 throughout MAC and OUT.
REQ-017 History indexing wraps modulo NTAPS; x[n-j] is read at (wptr_of_newest - j) mod 11.
REQ-018 cfg_we in IDLE with cfg_addr<=5 writes c[cfg_addr]; cfg_addr 6..7 is ignored without error.
REQ-019 cfg_we while busy=1 is dropped and cfg_err=1 for exactly the next cycle; coefficients stay unchanged during a computation.
REQ-020 When cfg_we and in_valid occur together in IDLE, the write lands first; the accepted sample uses the new coefficient.
REQ-021 flush in IDLE zeroes all 11 history entries and resets the write pointer; if in_valid is also high, flush takes priority and the sample is not accepted; flush while busy is ignored.

Reset
REQ-022 rst (asynchronous) forces: state=IDLE, history=0, wptr=0, acc=0, all coefficients=0, out_valid=0, out_data=0, cfg_err=0, busy=0; in_ready=1 from the first clock after rst deasserts.
REQ-023 rst asserted mid-MAC or in OUT abandons the computation; no out_valid is produced for that sample.

Structure
REQ-024 Package fir_pkg holds DW, CW, AW, NTAPS, NPAIRS, the output shift (7) and the FSM state encoding.
REQ-025 Sub-module fir_hist_buf: an 11-entry circular sample buffer with write, flush and two combinational read ports (pair operands); the FSM, coefficient bank and MAC stay in fir_seq.

Verification
REQ-026 Impulse: c0..c5=2,4,6,8,10,64, flush, then samples 64,0,0,...(11 total) -> out_data sequence 1,2,3,4,5,32,5,4,3,2,1.
REQ-027 DC max: all c=127, eleven samples of 127 -> 11th output = 16'h056A (1386).
REQ-028 Floor rounding: c5=1, others 0, flush, samples -1 then 5 zeros -> 6th output = 16'hFFFF.
REQ-029 Backpressure: out_ready held low 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, in_valid sample not accepted until after the handshake.
REQ-030 Config while busy: cfg_we at MAC cycle k=2 -> cfg_err pulses 1 cycle, coefficient readback unchanged, result matches the old coefficients.
REQ-031 rst pulse during MAC -> out_valid stays 0, coefficients read 0, next accepted sample produces out_data=0.
